// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream frame transmitter.
//
// Contents:
//   DataWidthDefault - default stream/buffer word width
//   DepthDefault     - default frame buffer depth in words
//   state_t          - transmitter FSM state encoding (StIdle, StSend, StFin)
package axis_pkg;

  localparam int unsigned DataWidthDefault = 32;
  localparam int unsigned DepthDefault     = 16;

  // Plain-vector encoding keeps the state register legacy-compatible with
  // older tools and waveform scripts that match on raw values.
  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StSend = 2'd1;
  localparam state_t StFin  = 2'd2;

endpackage

// File: rtl/axis_frame_buf.sv
// Frame buffer: register array with one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
//
// Ports:
//   clk_i     - clock, writes on rising edge
//   we_i      - write strobe (already qualified by the caller)
//   waddr_i   - write address
//   wdata_i   - write data
//   raddr_i   - read address
//   rdata_o   - read data, combinational from raddr_i
module axis_frame_buf
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDefault,
  parameter int unsigned DEPTH      = DepthDefault
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_frame_tx.sv
// AXI-Stream frame transmitter. A frame of frame_len words is written into
// a local buffer, then launched with a single-cycle start pulse and streamed
// out one beat per cycle from a registered output stage.
//
// Optional feature (macro AXIS_FRAME_TX_CHECKSUM_EN): append one extra beat
// carrying the XOR of all frame data words; TLAST moves to that beat.
//
// Ports:
//   ACLK, ARESETN       - clock and asynchronous active-low reset
//   wr_en/addr/data     - buffer write port, ignored while busy
//   start, frame_len    - launch request and beat count (1..DEPTH)
//   busy                - frame in flight (start accepted, final beat pending)
//   done                - one-cycle pulse after the final beat handshake
//   err                 - one-cycle pulse after a start with illegal length
//   M_AXIS_*            - AXI-Stream master; TVALID is purely registered
module axis_frame_tx
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDefault,
  parameter int unsigned DEPTH      = DepthDefault
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   frame_len,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic                     M_AXIS_TVALID,
  input  logic                     M_AXIS_TREADY,
  output logic                     M_AXIS_TLAST
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [AW:0] MaxLen = (AW+1)'(DEPTH);
  localparam logic [AW:0] One    = (AW+1)'(1);

  state_t                state_q, state_d;
  logic [AW:0]           len_q, len_d;
  // Index of the beat currently held in the output register.
  logic [AW:0]           ptr_q, ptr_d;
  logic [AW:0]           ptr_inc;
  // Index of the beat that carries TLAST.
  logic [AW:0]           last_idx;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  err_q, err_d;

  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  start_ok;
  logic                  start_tlast;
  logic                  hs;

  assign busy          = (state_q == StSend);
  assign done          = (state_q == StFin);
  assign err           = err_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;

  assign hs       = tvalid_q & M_AXIS_TREADY;
  assign ptr_inc  = ptr_q + One;
  assign start_ok = (frame_len != '0) && (frame_len <= MaxLen);

  // In IDLE the read port is parked on word 0 so a launch can load it
  // directly; while sending it looks one beat ahead. The wrap of ptr_inc at
  // DEPTH is harmless because the final beat never loads a successor.
  assign rd_addr = (state_q == StSend) ? ptr_inc[AW-1:0] : '0;

  axis_frame_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buf (
    .clk_i   (ACLK),
    .we_i    (wr_en & ~busy),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

`ifdef AXIS_FRAME_TX_CHECKSUM_EN
  // Running XOR of the data beats already handshaken.
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  assign last_idx    = len_q;
  assign start_tlast = 1'b0;
  // Beat index len_q is the checksum: fold in the final data word on the fly.
  assign next_word   = (ptr_inc == len_q) ? (csum_q ^ tdata_q) : rd_data;

  always_comb begin
    csum_d = csum_q;
    if (state_q == StIdle && start && start_ok) begin
      csum_d = '0;
    end else if (state_q == StSend && hs) begin
      csum_d = csum_q ^ tdata_q;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`else
  assign last_idx    = len_q - One;
  assign start_tlast = (frame_len == One);
  assign next_word   = rd_data;
`endif

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    err_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (start_ok) begin
            state_d  = StSend;
            len_d    = frame_len;
            ptr_d    = '0;
            tdata_d  = rd_data;
            tvalid_d = 1'b1;
            tlast_d  = start_tlast;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSend: begin
        if (hs) begin
          if (ptr_q == last_idx) begin
            state_d  = StFin;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            ptr_d   = ptr_inc;
            tdata_d = next_word;
            tlast_d = (ptr_inc == last_idx);
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d  = StIdle;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= StIdle;
      len_q    <= '0;
      ptr_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      ptr_q    <= ptr_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_axis_frame_tx.sv
module tb_axis_frame_tx;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic [4:0]  frame_len = '0;
  logic        busy, done, err;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b0;
  logic        M_AXIS_TLAST;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  axis_frame_tx #(
    .DATA_WIDTH (32),
    .DEPTH      (16)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .start         (start),
    .frame_len     (frame_len),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge ACLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] len);
    start = 1'b1; frame_len = len;
    @(posedge ACLK); #1;
    start = 1'b0;
  endtask

  // Collect beats against exp_q. mode 0: TREADY always high; mode 1: TREADY
  // pattern 1,0,0,1 repeating. Beats are sampled on the falling edge.
  task automatic collect(input int mode, input string tag);
    int k;
    bit fin;
    bit stalled;
    logic [31:0] held_d;
    logic held_l;
    k = 0; fin = 1'b0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    for (int c = 0; c < 64 && !fin; c++) begin
      M_AXIS_TREADY = (mode == 0) ? 1'b1 : !((c % 4 == 1) || (c % 4 == 2));
      @(negedge ACLK);
      if (stalled) begin
        chk({tag, "_stall_valid"}, M_AXIS_TVALID, 1'b1);
        chk({tag, "_stall_data"}, M_AXIS_TDATA, held_d);
        chk({tag, "_stall_last"}, M_AXIS_TLAST, held_l);
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (k < exp_q.size()) begin
          chk({tag, "_data"}, M_AXIS_TDATA, exp_q[k]);
          chk({tag, "_last"}, M_AXIS_TLAST, (k == exp_q.size() - 1));
        end
        if (mode == 0) chk({tag, "_cycle"}, c, k);
        k++;
        if (k >= exp_q.size()) fin = 1'b1;
      end
      stalled = M_AXIS_TVALID && !M_AXIS_TREADY;
      held_d  = M_AXIS_TDATA;
      held_l  = M_AXIS_TLAST;
      @(posedge ACLK); #1;
    end
    chk({tag, "_count"}, k, exp_q.size());
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_low"}, busy, 1'b0);
    chk({tag, "_valid_low"}, M_AXIS_TVALID, 1'b0);
    @(posedge ACLK); #1;
    chk({tag, "_done_clr"}, done, 1'b0);
    chk({tag, "_no_extra"}, M_AXIS_TVALID, 1'b0);
  endtask

  initial begin
    // Reset state.
    #2 ARESETN = 1'b0;
    #1;
    chk("rst_valid", M_AXIS_TVALID, 1'b0);
    chk("rst_last", M_AXIS_TLAST, 1'b0);
    chk("rst_data", M_AXIS_TDATA, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    @(posedge ACLK); @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    wr(4'd0, 32'h11);
    wr(4'd1, 32'h22);
    wr(4'd2, 32'h33);
    wr(4'd3, 32'h44);

    // Full-throughput frame of 4.
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
`ifdef AXIS_FRAME_TX_CHECKSUM_EN
    exp_q.push_back(32'h44);  // 11^22^33^44
`endif
    M_AXIS_TREADY = 1'b1;
    do_start(5'd4);
    chk("f4_valid_lat", M_AXIS_TVALID, 1'b1);
    chk("f4_busy", busy, 1'b1);
    collect(0, "f4");

    // Same frame under back-pressure.
    do_start(5'd4);
    collect(1, "f4stall");

    // Illegal lengths: 0 and DEPTH+1.
    do_start(5'd0);
    chk("len0_err", err, 1'b1);
    chk("len0_busy", busy, 1'b0);
    chk("len0_valid", M_AXIS_TVALID, 1'b0);
    @(posedge ACLK); #1;
    chk("len0_err_clr", err, 1'b0);
    chk("len0_valid2", M_AXIS_TVALID, 1'b0);
    do_start(5'd17);
    chk("len17_err", err, 1'b1);
    chk("len17_busy", busy, 1'b0);
    chk("len17_valid", M_AXIS_TVALID, 1'b0);
    @(posedge ACLK); #1;
    chk("len17_err_clr", err, 1'b0);

    // Reset while beat 2 is presented.
    M_AXIS_TREADY = 1'b1;
    do_start(5'd4);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    chk("mid_beat2", M_AXIS_TDATA, 32'h33);
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_valid", M_AXIS_TVALID, 1'b0);
    chk("mid_rst_data", M_AXIS_TDATA, 32'h0);
    chk("mid_rst_busy", busy, 1'b0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    chk("post_rst_idle", M_AXIS_TVALID, 1'b0);
    exp_q = '{32'h11, 32'h22};
`ifdef AXIS_FRAME_TX_CHECKSUM_EN
    exp_q.push_back(32'h33);  // 11^22
`endif
    do_start(5'd2);
    collect(0, "f2");

    // Write while busy is discarded; start while sending is ignored.
    M_AXIS_TREADY = 1'b0;
    do_start(5'd4);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hFF;
    start = 1'b1; frame_len = 5'd0;
    @(posedge ACLK); #1;
    wr_en = 1'b0; start = 1'b0;
    chk("busy_wr_err", err, 1'b0);
    chk("busy_wr_valid", M_AXIS_TVALID, 1'b1);
    chk("busy_wr_data0", M_AXIS_TDATA, 32'h11);
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
`ifdef AXIS_FRAME_TX_CHECKSUM_EN
    exp_q.push_back(32'h44);
`endif
    collect(0, "fwr1");
    do_start(5'd4);
    collect(0, "fwr2");

    // Single-beat frame.
    exp_q = '{32'h11};
`ifdef AXIS_FRAME_TX_CHECKSUM_EN
    exp_q.push_back(32'h11);
`endif
    do_start(5'd1);
    chk("f1_last", M_AXIS_TLAST, (exp_q.size() == 1));
    collect(0, "f1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_frame_tx.md
AXIS_FRAME_TX -- requirements
Module: axis_frame_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: stream and buffer word width.
REQ-002 SHALL have parameter DEPTH, default 16: frame buffer words (power of two, >=2); AW = clog2(DEPTH).
REQ-003 ACLK  in  1  sole clock, all state on rising edge.
REQ-004 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 wr_en  in  1  buffer write strobe.
REQ-006 wr_addr  in  AW  buffer write address.
REQ-007 wr_data  in  DATA_WIDTH  buffer write data.
REQ-008 start  in  1  single-cycle frame launch request.
REQ-009 frame_len  in  AW+1  beats to send, legal 1..DEPTH, sampled with start.
REQ-010 busy  out  1  high from accepted start until final beat handshakes.
REQ-011 done  out  1  one-cycle pulse the cycle after final beat handshake.
REQ-012 err  out  1  one-cycle pulse on rejected start.
REQ-013 M_AXIS_TDATA  out  DATA_WIDTH; M_AXIS_TVALID  out  1; M_AXIS_TREADY  in  1; M_AXIS_TLAST  out  1 -- AXI-Stream master.

Function
REQ-014 FSM states IDLE, SEND, FIN; IDLE->SEND on accepted start; SEND->FIN on final-beat handshake; FIN->IDLE unconditionally (done high in FIN).
REQ-015 Start accepted only in IDLE with 1<=frame_len<=DEPTH; otherwise err pulses next cycle, state unchanged; start in SEND/FIN ignored, no err.
REQ-016 Accepted start: latch length, load output register with buffer[0], TVALID high next cycle (latency 1).
REQ-017 Handshake = TVALID&TREADY; on each non-final handshake output register loads buffer[ptr+1] same edge, TVALID stays high (full throughput, one beat/cycle under constant TREADY).
REQ-018 TVALID never deasserts and TDATA/TLAST never change while TVALID high and TREADY low.
REQ-019 TLAST high only on beat index len-1; frame_len=1 gives a single beat with TLAST.
REQ-020 Buffer writes accepted only when busy low; writes while busy discarded; buffer read is combinational from a register array.
REQ-021 TVALID must not depend combinationally on TREADY.
REQ-022 Beat counter width AW+1; no wrap; frame_len=DEPTH reads addresses 0..DEPTH-1 exactly once.

Reset
REQ-023 ARESETN low: state IDLE, TVALID/TLAST/busy/done/err 0, TDATA 0, pointers 0, immediately (asynchronous), including mid-frame; buffer contents not reset.
REQ-024 After reset release no beat emitted until a new accepted start.

Configuration
REQ-025 Macro AXIS_FRAME_TX_CHECKSUM_EN defined: after the last data beat one extra beat carrying XOR of all frame data words is sent; TLAST moves to that beat; done follows its handshake.
REQ-026 Macro undefined: no checksum logic, frame is exactly frame_len beats.

Structure
REQ-027 Shared package axis_pkg SHALL hold state encoding typedef (IDLE/SEND/FIN) and DATA_WIDTH default constant.
REQ-028 One sub-module axis_frame_buf (register array, write port, async read port) is natural; FSM and output register stay in axis_frame_tx.

Verification
REQ-029 Write buffer[0..3]=0x11,0x22,0x33,0x44; start, len=4, TREADY=1 -> TVALID at cycle+1, beats 0x11..0x44 on consecutive cycles, TLAST on 0x44, done one cycle later.
REQ-030 Same frame, TREADY toggled 1,0,0,1,... -> no beat lost/duplicated, TDATA stable while stalled.
REQ-031 start with len=0 and len=DEPTH+1 -> err pulse, busy stays 0, no TVALID.
REQ-032 ARESETN low during beat 2 of len=4 -> TVALID 0 immediately; fresh start len=2 after release -> 0x11,0x22 with TLAST on 0x22.
REQ-033 With AXIS_FRAME_TX_CHECKSUM_EN, len=4 frame above -> five beats, fifth = 0x44 (0x11^0x22^0x33^0x44), TLAST only on fifth.
REQ-034 wr_en to addr 1 with 0xFF while busy -> transmitted beat 1 remains 0x22; next frame also sends 0x22.
